motion_bbox_tracker: RTL and testbench
======================================

MOTION_BBOX_TRACKER -- requirements
Module: motion_bbox_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MIN_HITS, default 30: minimum detected pixels per frame for a valid box.
REQ-003 Parameter HIT_W, default 16: hit counter width.
REQ-004 Port iCLK  input  1: pixel clock, the only clock.
REQ-005 Port iRST  input  1: synchronous, active-high reset.
REQ-006 Port iDVAL  input  1: pixel valid.
REQ-007 Port iObjectDetected  input  1: per-pixel motion flag from the frame-difference detector.
REQ-008 Port iX_Cont  input  10: pixel column.
REQ-009 Port iY_Cont  input  9: pixel row.
REQ-010 Port iFrame_Cont  input  32: frame counter; only bit 0 is used.
REQ-011 Port oBoxValid  output  1: published box meets MIN_HITS.
REQ-012 Ports oX_Min and oX_Max  output  10 each, and oY_Min and oY_Max  output  9 each: published bounding box.
REQ-013 Port oHitCount  output  HIT_W: published detected-pixel count.
REQ-014 Port oFrameDone  output  1: one-cycle pulse when a publish occurs.

Function
REQ-015 The block SHALL register iFrame_Cont[0] into frame_ff every cycle.
- Frame start: frame_ff=1 and iFrame_Cont[0]=0.
- Frame end: frame_ff=0 and iFrame_Cont[0]=1.
REQ-016 The state machine SHALL have three states: IDLE, ACCUM, PUBLISH.
REQ-017 IDLE->ACCUM on frame start; on entry, running box initialises to x_min=1023, y_min=511, x_max=0, y_max=0 and hit count to 0.
REQ-018 In ACCUM, each cycle with iDVAL & iObjectDetected SHALL update the running min/max with iX_Cont/iY_Cont and increment the hit count, saturating at all-ones (no wrap).
REQ-019 ACCUM->PUBLISH on frame end; pixels on the frame-end cycle SHALL NOT be accumulated.
REQ-020 In PUBLISH, for exactly one cycle:
- latch running box and count into the outputs;
- set oBoxValid = (count >= MIN_HITS);
- assert oFrameDone the following cycle;
- then go to IDLE.
REQ-021 Latency: oFrameDone and updated outputs SHALL be visible 2 cycles after the cycle iFrame_Cont[0] first reads 1.
REQ-022 Published outputs SHALL hold unchanged between publishes.
REQ-023 If count < MIN_HITS, box outputs SHALL still be latched, with oBoxValid=0.
REQ-024 A single detected pixel SHALL yield x_min=x_max and y_min=y_max at that pixel.
REQ-025 Frame start and frame end in consecutive cycles SHALL produce a publish with count 0 and oBoxValid=0.

Reset
REQ-026 On iRST=1 at a clock edge:
- state -> IDLE;
- oBoxValid, oFrameDone, oHitCount -> 0;
- oX_Min, oX_Max, oY_Min, oY_Max -> 0;
- frame_ff -> 1.
REQ-027 Reset asserted mid-ACCUM SHALL discard the partial frame; accumulation resumes only at the next frame start.

Configuration
REQ-028 Macro BBOX_OVERLAY_EN defined SHALL add the following ports and overlay behaviour:
- iDATA input 12; oRed, oGreen, oBlue output 12; oDVAL output 1.
- oDVAL=iDVAL, combinational.
- When oBoxValid=1 and the pixel lies on the published box perimeter (x equals min or max with y in range, or y equals min or max with x in range): oRed=12'hFFF, oGreen=0, oBlue=0.
- Otherwise all three outputs equal iDATA.
REQ-029 Without BBOX_OVERLAY_EN, these ports and the overlay logic SHALL be absent; tracking behaviour SHALL be identical.

Structure
REQ-030 Package motion_pkg SHALL hold X_W=10, Y_W=9, the state enum typedef bbox_state_t, and the box struct typedef bbox_t.
REQ-031 Overlay logic SHALL live in sub-module bbox_overlay, instantiated only under BBOX_OVERLAY_EN.

Verification
REQ-032 Scenario: 40 detections spanning x 100..200, y 50..80 in an even frame, then frame end -> oFrameDone pulse, box (100,200,50,80), oHitCount=40, oBoxValid=1.
REQ-033 Scenario: 29 detections -> oHitCount=29, oBoxValid=0, box latched.
REQ-034 Scenario: one detection at (5,7) -> box (5,5,7,7), oHitCount=1.
REQ-035 Scenario: reset asserted after 20 detections, released mid-frame, 50 more detections, frame end -> no publish; the next full frame publishes correctly.
REQ-036 Scenario: 70000 detections with HIT_W=16 -> oHitCount=65535.
REQ-037 Scenario (BBOX_OVERLAY_EN): box (10,20,10,20) valid; pixel (10,15) -> oRed=FFF, oGreen=0, oBlue=0; pixel (15,15) -> all outputs equal iDATA.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared widths, FSM state type and bounding-box record for the motion bbox tracker.
package motion_pkg;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PUBLISH
  } bbox_state_t;

  typedef struct packed {
    logic [X_W-1:0] xMin;
    logic [X_W-1:0] xMax;
    logic [Y_W-1:0] yMin;
    logic [Y_W-1:0] yMax;
  } bbox_t;

  // Inverted box: any real pixel shrinks min and grows max on first hit.
  localparam bbox_t BOX_EMPTY = '{xMin: '1, xMax: '0, yMin: '1, yMax: '0};

endpackage

// File: rtl/bbox_overlay.sv
// Paints the published box perimeter red over the incoming video when the box is valid.
module bbox_overlay
  import motion_pkg::*;
(
  input  logic           iBoxValid,
  input  bbox_t          iBox,
  input  logic [X_W-1:0] iX_Cont,
  input  logic [Y_W-1:0] iY_Cont,
  input  logic [11:0]    iDATA,
  output logic [11:0]    oRed,
  output logic [11:0]    oGreen,
  output logic [11:0]    oBlue
);

  logic xInRange, yInRange, onEdge;

  always_comb begin
    xInRange = (iX_Cont >= iBox.xMin) && (iX_Cont <= iBox.xMax);
    yInRange = (iY_Cont >= iBox.yMin) && (iY_Cont <= iBox.yMax);
    onEdge   = (((iX_Cont == iBox.xMin) || (iX_Cont == iBox.xMax)) && yInRange) ||
               (((iY_Cont == iBox.yMin) || (iY_Cont == iBox.yMax)) && xInRange);
    if (iBoxValid && onEdge) begin
      oRed   = '1;
      oGreen = '0;
      oBlue  = '0;
    end else begin
      oRed   = iDATA;
      oGreen = iDATA;
      oBlue  = iDATA;
    end
  end

endmodule

// File: rtl/motion_bbox_tracker.sv
// Per-frame bounding box of motion pixels, published once per even frame.
// Optional red perimeter overlay enabled by macro BBOX_OVERLAY_EN.
module motion_bbox_tracker
  import motion_pkg::*;
#(
  parameter int unsigned MIN_HITS = 30,
  parameter int unsigned HIT_W    = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic             iObjectDetected,
  input  logic [X_W-1:0]   iX_Cont,
  input  logic [Y_W-1:0]   iY_Cont,
  input  logic [31:0]      iFrame_Cont,
`ifdef BBOX_OVERLAY_EN
  input  logic [11:0]      iDATA,
  output logic [11:0]      oRed,
  output logic [11:0]      oGreen,
  output logic [11:0]      oBlue,
  output logic             oDVAL,
`endif
  output logic             oBoxValid,
  output logic [X_W-1:0]   oX_Min,
  output logic [X_W-1:0]   oX_Max,
  output logic [Y_W-1:0]   oY_Min,
  output logic [Y_W-1:0]   oY_Max,
  output logic [HIT_W-1:0] oHitCount,
  output logic             oFrameDone
);

  localparam logic [HIT_W-1:0] MIN_HITS_W = HIT_W'(MIN_HITS);

  bbox_state_t      state;
  bbox_t            runBox, pubBox;
  logic [HIT_W-1:0] hits;
  logic             frameFF, armed;
  logic             frameStart, frameEnd;
  logic             unusedFrameBits;

  assign unusedFrameBits = &{1'b0, iFrame_Cont[31:1]};

  // A start is honoured only after bit 0 has been seen high since reset, so a
  // reset released mid-frame cannot pick up the tail of that frame.
  assign frameStart = frameFF && !iFrame_Cont[0] && armed;
  assign frameEnd   = !frameFF && iFrame_Cont[0];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      frameFF    <= 1'b1;
      armed      <= 1'b0;
      runBox     <= BOX_EMPTY;
      hits       <= '0;
      pubBox     <= '0;
      oBoxValid  <= 1'b0;
      oHitCount  <= '0;
      oFrameDone <= 1'b0;
    end else begin
      frameFF    <= iFrame_Cont[0];
      armed      <= armed | iFrame_Cont[0];
      oFrameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (frameStart) begin
            state  <= ACCUM;
            runBox <= BOX_EMPTY;
            hits   <= '0;
          end
        end
        ACCUM: begin
          if (frameEnd) begin
            state <= PUBLISH;
          end else if (iDVAL && iObjectDetected) begin
            if (iX_Cont < runBox.xMin) runBox.xMin <= iX_Cont;
            if (iX_Cont > runBox.xMax) runBox.xMax <= iX_Cont;
            if (iY_Cont < runBox.yMin) runBox.yMin <= iY_Cont;
            if (iY_Cont > runBox.yMax) runBox.yMax <= iY_Cont;
            if (hits != '1) hits <= hits + 1'b1;
          end
        end
        PUBLISH: begin
          pubBox     <= runBox;
          oHitCount  <= hits;
          oBoxValid  <= (hits >= MIN_HITS_W);
          oFrameDone <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oX_Min = pubBox.xMin;
  assign oX_Max = pubBox.xMax;
  assign oY_Min = pubBox.yMin;
  assign oY_Max = pubBox.yMax;

`ifdef BBOX_OVERLAY_EN
  assign oDVAL = iDVAL;

  bbox_overlay uOverlay (
    .iBoxValid (oBoxValid),
    .iBox      (pubBox),
    .iX_Cont   (iX_Cont),
    .iY_Cont   (iY_Cont),
    .iDATA     (iDATA),
    .oRed      (oRed),
    .oGreen    (oGreen),
    .oBlue     (oBlue)
  );
`endif

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Directed bench for motion_bbox_tracker with a per-cycle reference model.
module tb_motion_bbox_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dval = 1'b0, det = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [31:0] fc = 32'd1;
  logic        oBoxValid, oFrameDone;
  logic [9:0]  oX_Min, oX_Max;
  logic [8:0]  oY_Min, oY_Max;
  logic [15:0] oHitCount;
`ifdef BBOX_OVERLAY_EN
  logic [11:0] idata = '0;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDVAL;
`endif

  int total = 0;
  int bad   = 0;
  bit chkEn = 0;

  always #5 clk = ~clk;

  motion_bbox_tracker #(.MIN_HITS(30), .HIT_W(16)) dut (
    .iCLK            (clk),
    .iRST            (rst),
    .iDVAL           (dval),
    .iObjectDetected (det),
    .iX_Cont         (x),
    .iY_Cont         (y),
    .iFrame_Cont     (fc),
`ifdef BBOX_OVERLAY_EN
    .iDATA           (idata),
    .oRed            (oRed),
    .oGreen          (oGreen),
    .oBlue           (oBlue),
    .oDVAL           (oDVAL),
`endif
    .oBoxValid       (oBoxValid),
    .oX_Min          (oX_Min),
    .oX_Max          (oX_Max),
    .oY_Min          (oY_Min),
    .oY_Max          (oY_Max),
    .oHitCount       (oHitCount),
    .oFrameDone      (oFrameDone)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 60) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the detections of a tracked frame and derives the box
  // from the whole list at publish time.
  int  phase = 0;               // 0 waiting for start, 1 collecting, 2 publish cycle
  bit  prevBit = 1, armedM = 0;
  int  qx[$], qy[$];
  int  eXmin = 0, eXmax = 0, eYmin = 0, eYmax = 0, eHit = 0;
  bit  eValid = 0, eDone = 0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; prevBit = 1; armedM = 0;
      eXmin = 0; eXmax = 0; eYmin = 0; eYmax = 0; eHit = 0; eValid = 0; eDone = 0;
      qx.delete(); qy.delete();
    end else begin
      eDone = 0;
      if (phase == 0) begin
        if (armedM && prevBit && !fc[0]) begin
          phase = 1; qx.delete(); qy.delete();
        end
      end else if (phase == 1) begin
        if (!prevBit && fc[0]) phase = 2;
        else if (dval && det) begin qx.push_back(int'(x)); qy.push_back(int'(y)); end
      end else begin
        eXmin = 1023; eXmax = 0; eYmin = 511; eYmax = 0;
        foreach (qx[i]) begin
          if (qx[i] < eXmin) eXmin = qx[i];
          if (qx[i] > eXmax) eXmax = qx[i];
          if (qy[i] < eYmin) eYmin = qy[i];
          if (qy[i] > eYmax) eYmax = qy[i];
        end
        eHit = (qx.size() > 65535) ? 65535 : qx.size();
        eValid = (eHit >= 30);
        eDone = 1;
        phase = 0;
      end
      prevBit = fc[0];
      armedM  = armedM | fc[0];
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("model_valid", 32'(oBoxValid), 32'(eValid));
      chk("model_done",  32'(oFrameDone), 32'(eDone));
      chk("model_xmin",  32'(oX_Min), eXmin);
      chk("model_xmax",  32'(oX_Max), eXmax);
      chk("model_ymin",  32'(oY_Min), eYmin);
      chk("model_ymax",  32'(oY_Max), eYmax);
      chk("model_hits",  32'(oHitCount), eHit);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, input bit d);
    dval = 1'b1; det = d; x = 10'(px); y = 9'(py);
    tick();
    dval = 1'b0; det = 1'b0;
  endtask

  task automatic startFrame();
    fc = fc + 1;
    tick();
  endtask

  // Ends the frame with a detected pixel on the end cycle; returns two cycles later.
  task automatic endFrame();
    fc = fc + 1;
    dval = 1'b1; det = 1'b1; x = '0; y = '0;
    tick();
    dval = 1'b0; det = 1'b0;
    tick();
  endtask

  task automatic pinPub(input string tag, input int xmn, input int xmx, input int ymn,
                        input int ymx, input int hc, input bit v);
    chk({tag, "_done"}, 32'(oFrameDone), 1);
    chk({tag, "_xmin"}, 32'(oX_Min), xmn);
    chk({tag, "_xmax"}, 32'(oX_Max), xmx);
    chk({tag, "_ymin"}, 32'(oY_Min), ymn);
    chk({tag, "_ymax"}, 32'(oY_Max), ymx);
    chk({tag, "_hits"}, 32'(oHitCount), hc);
    chk({tag, "_valid"}, 32'(oBoxValid), 32'(v));
    tick();
    chk({tag, "_pulse_end"}, 32'(oFrameDone), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chkEn = 1;
    tick();
    chk("reset_valid", 32'(oBoxValid), 0);
    chk("reset_hits",  32'(oHitCount), 0);
    chk("reset_xmax",  32'(oX_Max), 0);
    rst = 1'b0;
    tick(); tick();

    // 40 detections spanning x 100..200, y 50..80, with gated non-detections
    startFrame(); tick();
    for (int i = 0; i < 40; i++) begin
      pix((i == 39) ? 200 : 100 + 2 * i, 50 + (i % 31), 1'b1);
      pix(900, 400, 1'b0);
    end
    det = 1'b1; x = 10'd1; y = 9'd1; tick(); det = 1'b0;
    endFrame();
    pinPub("s40", 100, 200, 50, 80, 40, 1'b1);
    repeat (5) tick();
    chk("hold_hits", 32'(oHitCount), 40);

    // 29 detections: box latched but below threshold
    startFrame();
    for (int i = 0; i < 29; i++) pix(300 + i, 100 + (i % 5), 1'b1);
    endFrame();
    pinPub("s29", 300, 328, 100, 104, 29, 1'b0);

    // single detection
    startFrame(); tick();
    pix(5, 7, 1'b1);
    endFrame();
    pinPub("s1", 5, 5, 7, 7, 1, 1'b0);

    // start and end on consecutive cycles: empty box
    tick();
    startFrame();
    endFrame();
    pinPub("s0", 1023, 0, 511, 0, 0, 1'b0);

    // exactly MIN_HITS with extreme coordinates
    startFrame();
    pix(1023, 511, 1'b1);
    pix(0, 0, 1'b1);
    for (int i = 0; i < 28; i++) pix(500, 200, 1'b1);
    endFrame();
    pinPub("edge", 0, 1023, 0, 511, 30, 1'b1);

    // reset in the middle of a frame discards it
    startFrame();
    for (int i = 0; i < 20; i++) pix(40, 40, 1'b1);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_mid_hits", 32'(oHitCount), 0);
    for (int i = 0; i < 50; i++) pix(60, 60, 1'b1);
    endFrame();
    chk("rst_nopub_done", 32'(oFrameDone), 0);
    chk("rst_nopub_hits", 32'(oHitCount), 0);
    repeat (3) tick();
    startFrame();
    for (int i = 0; i < 35; i++) pix(70 + i, 20, 1'b1);
    endFrame();
    pinPub("after_rst", 70, 104, 20, 20, 35, 1'b1);

    // hit counter saturation
    startFrame();
    for (int i = 0; i < 70000; i++) pix(1, 1, 1'b1);
    endFrame();
    pinPub("sat", 1, 1, 1, 1, 65535, 1'b1);

`ifdef BBOX_OVERLAY_EN
    startFrame();
    pix(10, 10, 1'b1);
    pix(20, 20, 1'b1);
    for (int i = 0; i < 28; i++) pix(15, 15, 1'b1);
    endFrame();
    pinPub("ovl_box", 10, 20, 10, 20, 30, 1'b1);
    idata = 12'h5A5; dval = 1'b1; x = 10'd10; y = 9'd15; #1;
    chk("ovl_edge_r", 32'(oRed), 32'hFFF);
    chk("ovl_edge_g", 32'(oGreen), 0);
    chk("ovl_edge_b", 32'(oBlue), 0);
    chk("ovl_dval", 32'(oDVAL), 1);
    x = 10'd15; #1;
    chk("ovl_in_r", 32'(oRed), 32'h5A5);
    chk("ovl_in_g", 32'(oGreen), 32'h5A5);
    chk("ovl_in_b", 32'(oBlue), 32'h5A5);
    dval = 1'b0;
    tick();
`endif

    repeat (3) tick();
    chkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
